// File: rtl/loader_pkg.sv
// Shared types and RV32I encoding constants for the instruction loader.
// Covers the field-tuple op codes, the opcode/funct3 fields and the loader FSM states.
package loader_pkg;

  typedef enum logic [1:0] {
    OP_ADDI = 2'b00,
    OP_SW   = 2'b01,
    OP_LW   = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_W   = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/rv_instr_encoder.sv
// Combinational RV32I encoder for the addi/sw/lw subset used by the loader.
// The reserved op yields a zero word and flags illegal.
module rv_instr_encoder
  import loader_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Pack the fields into the instruction format selected by op.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (op)
      OP_ADDI: word = {imm, rs1, FUNCT3_ADD, rd, OPC_OPIMM};
      OP_LW:   word = {imm, rs1, FUNCT3_W, rd, OPC_LOAD};
      OP_SW:   word = {imm[11:5], rs2, rs1, FUNCT3_W, imm[4:0], OPC_STORE};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader_encoder.sv
// Encodes a stream of addi/sw/lw field tuples and writes them to consecutive memory words.
// Optional readback check after every write is enabled by defining LOADER_VERIFY_EN.
module instr_loader_encoder
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic [ADDR_W-1:0] mem_select,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [ADDR_W-1:0] sel_r, sel_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic [ADDR_W:0]   count_r, count_s;
  logic [2:0]        err_r, err_s;
  logic              last_r, last_s;
  logic              write_r, write_s;
  logic              ready_r, ready_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;

  logic [31:0]       enc_word_s;
  logic              enc_illegal_s;
  logic              accept_s;
  logic              wrap_s;
  state_e            fin_state_s;
  logic [ADDR_W-1:0] fin_addr_s;

  rv_instr_encoder u_enc (
    .op      (op_e'(in_op)),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (enc_word_s),
    .illegal (enc_illegal_s)
  );

  // The last word of memory ends the session instead of wrapping to 0.
  assign accept_s    = in_valid && ready_r;
  assign wrap_s      = (addr_r == ADDR_MAX);
  assign fin_state_s = (wrap_s || last_r) ? ST_DONE : ST_LOAD;
  assign fin_addr_s  = wrap_s ? addr_r : (addr_r + ADDR_ONE);

`ifndef LOADER_VERIFY_EN
  logic unused_rdata_s;
  assign unused_rdata_s = ^mem_rdata;
`endif

  // Next-state and next-output computation.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    sel_s   = sel_r;
    data_s  = data_r;
    count_s = count_r;
    err_s   = err_r;
    last_s  = last_r;
    write_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_s  = base_addr;
          count_s = '0;
          err_s   = 3'b000;
          state_s = ST_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (accept_s && enc_illegal_s) begin
          err_s[0] = 1'b1;
          state_s  = in_last ? ST_DONE : ST_LOAD;
        end else if (accept_s) begin
          sel_s   = addr_r;
          data_s  = DATA_W'(enc_word_s);
          last_s  = in_last;
          write_s = 1'b1;
          state_s = ST_WRITE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
`ifdef LOADER_VERIFY_EN
        state_s = ST_CHECK;
`else
        state_s  = fin_state_s;
        addr_s   = fin_addr_s;
        count_s  = count_r + COUNT_ONE;
        err_s[1] = err_r[1] | wrap_s;
`endif
      end
      ST_CHECK: begin
`ifdef LOADER_VERIFY_EN
        // mem_select is still held, so mem_rdata reflects the word just written.
        if (mem_rdata != data_r) begin
          err_s[2] = 1'b1;
        end else begin
          err_s[2] = err_r[2];
        end
        state_s  = fin_state_s;
        addr_s   = fin_addr_s;
        count_s  = count_r + COUNT_ONE;
        err_s[1] = err_r[1] | wrap_s;
`else
        state_s = ST_IDLE;
`endif
      end
      default: state_s = ST_IDLE;
    endcase
    ready_s = (state_s == ST_LOAD);
    busy_s  = (state_s == ST_LOAD) || (state_s == ST_WRITE) || (state_s == ST_CHECK);
    done_s  = (state_s == ST_DONE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      sel_r   <= '0;
      data_r  <= '0;
      count_r <= '0;
      err_r   <= 3'b000;
      last_r  <= 1'b0;
      write_r <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      sel_r   <= sel_s;
      data_r  <= data_s;
      count_r <= count_s;
      err_r   <= err_s;
      last_r  <= last_s;
      write_r <= write_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign in_ready   = ready_r;
  assign mem_select = sel_r;
  assign mem_data   = data_r;
  assign mem_write  = write_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign count      = count_r;

endmodule

// File: tb/tb_instr_loader_encoder.sv
// Directed bench for instr_loader_encoder: hand-encoded words, illegal op, top-of-memory stop,
// reset during a write and (with LOADER_VERIFY_EN) the readback check.
module tb_instr_loader_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = 10'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [11:0] in_imm = 12'd0;
  logic        in_last = 1'b0;
  logic [9:0]  mem_select;
  logic [31:0] mem_data;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [2:0]  err;
  logic [10:0] count;

  logic [31:0] mem [0:1023];
  logic        zero_mode = 1'b0;
  logic [9:0]  log_sel [0:63];
  logic [31:0] log_dat [0:63];
  int          wr_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  instr_loader_encoder dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .mem_select (mem_select),
    .mem_data   (mem_data),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count)
  );

  always #5 clock = ~clock;

  assign mem_rdata = zero_mode ? 32'h0000_0000 : mem[mem_select];

  // Memory model plus a log of every write strobe.
  always @(posedge clock) begin
    if (mem_write) begin
      mem[mem_select] <= mem_data;
      if (wr_cnt < 64) begin
        log_sel[wr_cnt] <= mem_select;
        log_dat[wr_cnt] <= mem_data;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_start(input logic [9:0] base);
    @(negedge clock);
    start = 1'b1;
    base_addr = base;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Presents one tuple from a negedge; returns at the negedge after acceptance (or on budget expiry).
  task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm, input logic last,
                      input int budget, output logic acc);
    acc = 1'b0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (in_ready) begin
        @(posedge clock);
        acc = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (acc) @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      @(negedge clock);
    end
  endtask

  initial begin
    logic acc;
    int   w0;

    // Reset values
    repeat (3) @(negedge clock);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_mem_select", mem_select, 0);
    check_eq("rst_mem_data", mem_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_count", count, 0);
    reset = 1'b0;

    // Single addi x1, x0, 1 at address 0
    w0 = wr_cnt;
    do_start(10'd0);
    check_eq("t1_busy", busy, 1);
    send(2'b00, 5'd1, 5'd0, 5'd0, 12'd1, 1'b1, 10, acc);
    check_eq("t1_accepted", acc, 1);
    check_eq("t1_strobe", mem_write, 1);
    check_eq("t1_select", mem_select, 0);
    check_eq("t1_data", mem_data, 32'h0010_0093);
    check_eq("t1_ready_low", in_ready, 0);
    wait_done(10);
    check_eq("t1_done", done, 1);
    check_eq("t1_busy_low", busy, 0);
    check_eq("t1_count", count, 1);
    check_eq("t1_nwrites", wr_cnt - w0, 1);
    check_eq("t1_idle_strobe", mem_write, 0);

    // sw then lw at consecutive addresses, with in_ready re-rise latency
    w0 = wr_cnt;
    do_start(10'd100);
    send(2'b01, 5'd0, 5'd0, 5'd1, 12'h200, 1'b0, 10, acc);
    check_eq("t2_sw_accepted", acc, 1);
    check_eq("t2_ready_n1", in_ready, 0);
    @(negedge clock);
`ifdef LOADER_VERIFY_EN
    check_eq("t2_ready_n2", in_ready, 0);
    @(negedge clock);
`endif
    check_eq("t2_ready_back", in_ready, 1);
    send(2'b10, 5'd2, 5'd0, 5'd0, 12'h200, 1'b1, 10, acc);
    check_eq("t2_lw_accepted", acc, 1);
    wait_done(10);
    check_eq("t2_done", done, 1);
    check_eq("t2_nwrites", wr_cnt - w0, 2);
    check_eq("t2_sw_sel", log_sel[w0], 100);
    check_eq("t2_sw_data", log_dat[w0], 32'h2010_2023);
    check_eq("t2_lw_sel", log_sel[w0+1], 101);
    check_eq("t2_lw_data", log_dat[w0+1], 32'h2000_2103);
    check_eq("t2_count", count, 2);
    check_eq("t2_err", err, 0);

    // Illegal op mid-stream
    w0 = wr_cnt;
    do_start(10'd200);
    send(2'b00, 5'd3, 5'd0, 5'd0, 12'd5, 1'b0, 10, acc);
    wait_done(2);
    send(2'b11, 5'd9, 5'd9, 5'd9, 12'hfff, 1'b0, 10, acc);
    check_eq("t3_ill_accepted", acc, 1);
    check_eq("t3_ill_no_strobe", mem_write, 0);
    check_eq("t3_ill_err", err, 3'b001);
    check_eq("t3_ill_ready", in_ready, 1);
    send(2'b00, 5'd4, 5'd0, 5'd0, 12'd7, 1'b1, 10, acc);
    wait_done(10);
    check_eq("t3_nwrites", wr_cnt - w0, 2);
    check_eq("t3_sel0", log_sel[w0], 200);
    check_eq("t3_data0", log_dat[w0], 32'h0050_0193);
    check_eq("t3_sel1", log_sel[w0+1], 201);
    check_eq("t3_data1", log_dat[w0+1], 32'h0070_0213);
    check_eq("t3_count", count, 2);
    check_eq("t3_err_sticky", err, 3'b001);

    // Top-of-memory stop
    w0 = wr_cnt;
    do_start(10'd1023);
    check_eq("t4_err_cleared", err, 0);
    send(2'b00, 5'd5, 5'd0, 5'd0, 12'd9, 1'b0, 10, acc);
    wait_done(10);
    check_eq("t4_done", done, 1);
    check_eq("t4_err", err, 3'b010);
    check_eq("t4_count", count, 1);
    send(2'b00, 5'd6, 5'd0, 5'd0, 12'd1, 1'b1, 8, acc);
    check_eq("t4_second_rejected", acc, 0);
    check_eq("t4_nwrites", wr_cnt - w0, 1);
    check_eq("t4_sel", log_sel[w0], 1023);
    check_eq("t4_data", log_dat[w0], 32'h0090_0293);

    // Reset during the write cycle
    do_start(10'd300);
    send(2'b00, 5'd7, 5'd0, 5'd0, 12'd3, 1'b0, 10, acc);
    check_eq("t5_strobe", mem_write, 1);
    reset = 1'b1;
    @(negedge clock);
    check_eq("t5_mem_write", mem_write, 0);
    check_eq("t5_in_ready", in_ready, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_done", done, 0);
    check_eq("t5_count", count, 0);
    check_eq("t5_select", mem_select, 0);
    check_eq("t5_data", mem_data, 0);
    check_eq("t5_err", err, 0);
    reset = 1'b0;

    // Readback check: forced-zero memory, then matching memory
    zero_mode = 1'b1;
    do_start(10'd400);
    send(2'b00, 5'd8, 5'd0, 5'd0, 12'd2, 1'b1, 10, acc);
    wait_done(10);
    check_eq("t6_zero_done", done, 1);
`ifdef LOADER_VERIFY_EN
    check_eq("t6_zero_err", err, 3'b100);
`else
    check_eq("t6_zero_err", err, 3'b000);
`endif
    zero_mode = 1'b0;
    do_start(10'd401);
    send(2'b00, 5'd8, 5'd0, 5'd0, 12'd2, 1'b1, 10, acc);
    wait_done(10);
    check_eq("t6_match_done", done, 1);
    check_eq("t6_match_err", err, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
